ahb_dma_master: RTL
===================

# ahb_dma_master

Single-channel AHB-Lite bus master that drives the forward-transform SoC's bus inputs. It copies a block of 32-bit words from one slave address range (e.g. SRAM controller, holding accelerator output) to another (e.g. SDRAM controller). Each word is moved as one non-pipelined read followed by one non-pipelined write. The block replaces the testbench master upstream of the SoC's `in_HADDR`, `in_HWRITE`, `in_HWDATA`, `out_HRDATA` and `out_HREADY`.

## Interface
- `IDLE_ADDR`, default 32'hFFFF_FFF0: parking address driven whenever no address phase is active; must decode to the default slave.
- `CNT_W`, default 16: width of the word counter.
- `in_HCLK` input 1: bus clock; all state changes on the rising edge.
- `in_HRESET` input 1: reset, asynchronous, active-low.
- `in_HREADY` input 1: bus HREADY from the s2m mux.
- `in_HRDATA` input 32: bus read data.
- `out_HADDR` output 32: bus address.
- `out_HWRITE` output 1: bus write strobe.
- `out_HWDATA` output 32: bus write data.
- `in_start` input 1: one-cycle request to start a copy; sampled only in IDLE.
- `in_abort` input 1: stop request; level, sampled every cycle while busy.
- `in_src_addr` input 32: source byte address; bits [1:0] ignored.
- `in_dst_addr` input 32: destination byte address; bits [1:0] ignored.
- `in_word_count` input CNT_W: number of words to copy.
- `out_busy` output 1: high in every state except IDLE.
- `out_done` output 1: one-cycle pulse when a copy completes normally.
- `out_aborted` output 1: one-cycle pulse when a copy ends through abort.
- `out_words_done` output CNT_W: number of words fully written in the current or last copy.

## Operation
- **Reset values** (applied asynchronously while `in_HRESET`=0):
  - `out_HADDR`=IDLE_ADDR, `out_HWRITE`=0, `out_HWDATA`=0.
  - `out_busy`=0, `out_done`=0, `out_aborted`=0, `out_words_done`=0.
  - State=IDLE; the source, destination, remaining-count and data registers reset to 0.
- **Reset mid-copy:** the transfer is dropped and the bus is released immediately. No done or aborted pulse is issued.
- **States:** IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- **IDLE:**
  - Bus outputs are parked: HADDR=IDLE_ADDR, HWRITE=0.
  - On `in_start`=1: latch `{src[31:2],2'b00}`, `{dst[31:2],2'b00}` and count, clear `out_words_done`.
  - If count≠0, go to RD_A. If count=0, go to FIN with no bus traffic.
- **RD_A:**
  - Drive HADDR=src, HWRITE=0.
  - If `in_HREADY`=1, go to RD_D; otherwise hold (address phase extended).
- **RD_D:**
  - HADDR=IDLE_ADDR, HWRITE=0.
  - On `in_HREADY`=1, capture `in_HRDATA` into the data register and go to WR_A.
- **WR_A:**
  - Drive HADDR=dst, HWRITE=1.
  - If `in_HREADY`=1, go to WR_D.
- **WR_D:**
  - HADDR=IDLE_ADDR, HWRITE=0, HWDATA=data register.
  - On `in_HREADY`=1: src+=4, dst+=4, remaining−=1, `out_words_done`+=1.
  - Next state is FIN if remaining was 1 or abort is pending; otherwise RD_A.
- **FIN:** for one cycle, pulse `out_done` (normal end) or `out_aborted` (abort end), then go to IDLE.
- **Abort:**
  - `in_abort`=1 seen in any busy state sets an abort-pending flag.
  - An in-flight data phase always completes, because AHB does not allow cancelling it.
  - RD_A/WR_A with abort pending and `in_HREADY`=1 still advance to their data phase. A read that has started is finished by its write before the block stops.
  - Abort while in FIN (normal end already decided) is ignored.
- **Arithmetic:**
  - Address increments wrap modulo 2^32.
  - The count is unsigned CNT_W bits; the maximum copy is 2^CNT_W−1 words.
- **`in_start` while busy** is ignored and does not queue.
- **`out_HWDATA`** holds its last value outside WR_D; it is only meaningful during WR_D.

## Timing
- The AHB address-to-data pipeline is honoured. HWDATA is valid in the cycle after the write address is accepted, and stays valid until `in_HREADY`=1.
- Zero-wait-state slaves: 4 cycles per word (RD_A, RD_D, WR_A, WR_D).
- Total copy time for N words = 1 (IDLE→RD_A) + 4N + 1 (FIN).
- Each slave wait cycle adds one cycle to the data phase concerned.
- `out_busy` rises the cycle after `in_start` and falls when FIN exits.
- `out_done`/`out_aborted` are high for exactly one cycle and never high together.
- `in_HRDATA` is sampled only on the RD_D cycle with `in_HREADY`=1.

## Test plan
- **Basic copy:** src=0x0000_0100, dst=0x4000_0000, count=4; slave returns 0xA0..0xA3, zero wait → writes at 0x4000_0000..0x4000_000C carry 0xA0..0xA3; `out_done` at cycle 18; `out_words_done`=4.
- **Wait states:** same copy with 2 wait cycles on every data phase → HWDATA stable through the waits; total 34 cycles; data correct.
- **Zero count:** count=0 → no non-IDLE_ADDR address on the bus; `out_done` pulses 1 cycle after start.
- **Abort:** count=8, `in_abort` asserted during RD_D of word 3 → word 3 is written; `out_aborted`=1 for one cycle; `out_words_done`=3; `out_done` never asserted.
- **Reset mid-copy:** `in_HRESET` driven low during WR_D → all outputs at reset values in the same cycle; after release, a new copy runs normally.
- **Wrap:** src=0xFFFF_FFF8, count=3 → read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Separately, `in_start` during busy is ignored.

Source files
------------

// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite DMA master: copies a block of 32-bit words, one read then one write per word.
// Latency: 1 + 4N + 1 cycles for N words with zero-wait slaves; each slave wait cycle adds one cycle.
// Backpressure: in_HREADY low stretches the current data phase; all bus outputs are registered and held.
//
// Ports:
//   in_HCLK, in_HRESET          bus clock, async active-low reset
//   in_HREADY, in_HRDATA        slave response (s2m mux)
//   out_HADDR/HWRITE/HWDATA     master request; HADDR parks at IDLE_ADDR when no address phase
//   in_start, in_abort          control; start sampled in IDLE, abort is a level sampled while busy
//   in_src_addr, in_dst_addr    byte addresses, bits [1:0] ignored
//   in_word_count               words to copy (0 completes immediately)
//   out_busy/done/aborted       status; done/aborted are one-cycle pulses
//   out_words_done              words fully written in the current or last copy
module ahb_dma_master #(
  parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFF0,
  parameter int          CNT_W     = 16
) (
  input  logic             in_HCLK,
  input  logic             in_HRESET,
  input  logic             in_HREADY,
  input  logic [31:0]      in_HRDATA,
  output logic [31:0]      out_HADDR,
  output logic             out_HWRITE,
  output logic [31:0]      out_HWDATA,
  input  logic             in_start,
  input  logic             in_abort,
  input  logic [31:0]      in_src_addr,
  input  logic [31:0]      in_dst_addr,
  input  logic [CNT_W-1:0] in_word_count,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_aborted,
  output logic [CNT_W-1:0] out_words_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_D = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t           state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] rem_q;
  logic             abort_pend;
  logic             abort_seen;

  // Byte-lane bits of the addresses are deliberately dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{in_src_addr[1:0], in_dst_addr[1:0]};

  // An abort arriving in the same cycle a write completes still counts.
  assign abort_seen = abort_pend | in_abort;

  // Bus outputs are registered: each one is loaded on the transition into the
  // state that needs it, so they are glitch-free and already valid on entry.
  always_ff @(posedge in_HCLK or negedge in_HRESET) begin
    if (!in_HRESET) begin
      state          <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      data_q         <= '0;
      rem_q          <= '0;
      abort_pend     <= 1'b0;
      out_HADDR      <= IDLE_ADDR;
      out_HWRITE     <= 1'b0;
      out_HWDATA     <= '0;
      out_busy       <= 1'b0;
      out_done       <= 1'b0;
      out_aborted    <= 1'b0;
      out_words_done <= '0;
    end else begin
      out_done    <= 1'b0;
      out_aborted <= 1'b0;

      // FIN is excluded: once the end is decided an abort has nothing to stop.
      if (state != IDLE && state != FIN && in_abort)
        abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          out_HADDR  <= IDLE_ADDR;
          out_HWRITE <= 1'b0;
          abort_pend <= 1'b0;
          if (in_start) begin
            src_q          <= {in_src_addr[31:2], 2'b00};
            dst_q          <= {in_dst_addr[31:2], 2'b00};
            rem_q          <= in_word_count;
            out_words_done <= '0;
            out_busy       <= 1'b1;
            if (in_word_count != '0) begin
              state     <= RD_A;
              out_HADDR <= {in_src_addr[31:2], 2'b00};
            end else begin
              state    <= FIN;
              out_done <= 1'b1;
            end
          end
        end

        RD_A: begin
          if (in_HREADY) begin
            state     <= RD_D;
            out_HADDR <= IDLE_ADDR;
          end
        end

        RD_D: begin
          if (in_HREADY) begin
            data_q     <= in_HRDATA;
            state      <= WR_A;
            out_HADDR  <= dst_q;
            out_HWRITE <= 1'b1;
          end
        end

        WR_A: begin
          if (in_HREADY) begin
            state      <= WR_D;
            out_HADDR  <= IDLE_ADDR;
            out_HWRITE <= 1'b0;
            out_HWDATA <= data_q;
          end
        end

        WR_D: begin
          if (in_HREADY) begin
            src_q          <= src_q + 32'd4;
            dst_q          <= dst_q + 32'd4;
            rem_q          <= rem_q - CNT_W'(1);
            out_words_done <= out_words_done + CNT_W'(1);
            if (rem_q == CNT_W'(1) || abort_seen) begin
              state <= FIN;
              // Having moved every word is a normal end even if abort was also asked for.
              if (rem_q == CNT_W'(1))
                out_done <= 1'b1;
              else
                out_aborted <= 1'b1;
            end else begin
              state     <= RD_A;
              out_HADDR <= src_q + 32'd4;
            end
          end
        end

        FIN: begin
          state    <= IDLE;
          out_busy <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
